// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with a selectable standard or
// first-word-fall-through read port, run-time programmable almost-full and
// almost-empty thresholds, an exact fill-level output, a synchronous flush,
// and sticky overflow/underflow error flags.
module sync_fifo_prog #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int FWFT       = 0,
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic [ADDR_WIDTH:0]   afull_thresh,
    input  logic [ADDR_WIDTH:0]   aempty_thresh,
    input  logic                  clr_err,
    output logic                  full,
    output logic                  empty,
    output logic                  afull,
    output logic                  aempty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] L_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] L_ZERO  = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0] L_DEPTH = (ADDR_WIDTH+1)'(FIFO_DEPTH);

    // Storage is deliberately left without reset; pointers define validity.
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_aempty;
    logic                  r_overflow;
    logic                  r_underflow;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic                  w_wr_vld;
    logic                  w_rd_vld;
    logic                  w_ovf_set;
    logic                  w_udf_set;
    logic [ADDR_WIDTH:0]   w_count_nxt;
    logic                  w_full_nxt;
    logic                  w_empty_nxt;
    logic                  w_afull_nxt;
    logic                  w_aempty_nxt;
    logic [ADDR_WIDTH-1:0] w_wr_idx;
    logic [ADDR_WIDTH-1:0] w_rd_idx;

    // Accepted operations: writes blocked while full, reads blocked while empty.
    always_comb begin
        w_wr_vld  = wr_en & ~r_full;
        w_rd_vld  = rd_en & ~r_empty;
        w_ovf_set = wr_en & r_full;
        w_udf_set = rd_en & r_empty;
        w_wr_idx  = r_wr_ptr[ADDR_WIDTH-1:0];
        w_rd_idx  = r_rd_ptr[ADDR_WIDTH-1:0];
    end

    // Next fill level and the flags derived from it, so flags move with count.
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_vld && !w_rd_vld) begin
            w_count_nxt = r_count + L_ONE;
        end else if (w_rd_vld && !w_wr_vld) begin
            w_count_nxt = r_count - L_ONE;
        end else begin
            w_count_nxt = r_count;
        end
        w_full_nxt   = (w_count_nxt == L_DEPTH);
        w_empty_nxt  = (w_count_nxt == L_ZERO);
        w_afull_nxt  = (w_count_nxt >= afull_thresh);
        w_aempty_nxt = (w_count_nxt <= aempty_thresh);
    end

    // Pointer, count, flag and sticky-error state; flush restores reset values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= L_ZERO;
            r_rd_ptr    <= L_ZERO;
            r_count     <= L_ZERO;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_afull     <= 1'b0;
            r_aempty    <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= L_ZERO;
            r_rd_ptr    <= L_ZERO;
            r_count     <= L_ZERO;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_afull     <= 1'b0;
            r_aempty    <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_vld) begin
                r_wr_ptr <= r_wr_ptr + L_ONE;
            end
            if (w_rd_vld) begin
                r_rd_ptr <= r_rd_ptr + L_ONE;
            end
            r_count     <= w_count_nxt;
            r_full      <= w_full_nxt;
            r_empty     <= w_empty_nxt;
            r_afull     <= w_afull_nxt;
            r_aempty    <= w_aempty_nxt;
            // A new error event in the same cycle wins over clr_err.
            r_overflow  <= w_ovf_set | (r_overflow & ~clr_err);
            r_underflow <= w_udf_set | (r_underflow & ~clr_err);
        end
    end

    // Storage write; a flushing cycle discards the concurrent write.
    always_ff @(posedge clk) begin
        if (w_wr_vld && !flush) begin
            r_mem[w_wr_idx] <= wr_data;
        end
    end

    // Standard-mode read register: loads the head word on an accepted pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= {DATA_WIDTH{1'b0}};
        end else if ((FWFT == 0) && w_rd_vld && !flush) begin
            r_rd_data <= r_mem[w_rd_idx];
        end
    end

    // Read port: FWFT shows the head word whenever data is present, zero otherwise.
    always_comb begin
        rd_data = r_rd_data;
        if (FWFT != 0) begin
            if (r_empty) begin
                rd_data = {DATA_WIDTH{1'b0}};
            end else begin
                rd_data = r_mem[w_rd_idx];
            end
        end else begin
            rd_data = r_rd_data;
        end
    end

    assign full      = r_full;
    assign empty     = r_empty;
    assign afull     = r_afull;
    assign aempty    = r_aempty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed testbench for sync_fifo_prog: one standard-mode and one FWFT
// instance share the same stimulus; expected values are hand-computed.
module tb_sync_fifo_prog;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW:0]   afull_th;
    logic [AW:0]   aempty_th;
    logic          clr_err;

    logic [DW-1:0] s_rd_data, f_rd_data;
    logic          s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
    logic          f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
    logic [AW:0]   s_count, f_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_d;
    logic [DW-1:0] last_d;

    sync_fifo_prog #(.DATA_WIDTH(DW), .FIFO_DEPTH(16), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(s_rd_data), .afull_thresh(afull_th),
        .aempty_thresh(aempty_th), .clr_err(clr_err), .full(s_full),
        .empty(s_empty), .afull(s_afull), .aempty(s_aempty), .count(s_count),
        .overflow(s_ovf), .underflow(s_udf)
    );

    sync_fifo_prog #(.DATA_WIDTH(DW), .FIFO_DEPTH(16), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(f_rd_data), .afull_thresh(afull_th),
        .aempty_thresh(aempty_th), .clr_err(clr_err), .full(f_full),
        .empty(f_empty), .afull(f_afull), .aempty(f_aempty), .count(f_count),
        .overflow(f_ovf), .underflow(f_udf)
    );

    // 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed sequence.
    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0;
        clr_err = 1'b0; afull_th = 5'd12; aempty_th = 5'd2;
        #12;
        chk("rst_count", 32'(s_count), 32'd0);
        chk("rst_empty", 32'(s_empty), 32'd1);
        chk("rst_full", 32'(s_full), 32'd0);
        chk("rst_afull", 32'(s_afull), 32'd0);
        chk("rst_aempty", 32'(s_aempty), 32'd1);
        chk("rst_ovf", 32'(s_ovf), 32'd0);
        chk("rst_udf", 32'(s_udf), 32'd0);
        chk("rst_rd_std", 32'(s_rd_data), 32'd0);
        chk("rst_rd_fwft", 32'(f_rd_data), 32'd0);
        #10 rst = 1'b0;

        // Three writes, then three reads with one-cycle read latency.
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 8'(8'h11 * (i + 1));
            tick();
        end
        wr_en = 1'b0;
        chk("w3_count", 32'(s_count), 32'd3);
        chk("w3_empty", 32'(s_empty), 32'd0);
        chk("w3_aempty", 32'(s_aempty), 32'd0);
        chk("w3_fwft_head", 32'(f_rd_data), 32'h11);
        chk("w3_std_idle", 32'(s_rd_data), 32'h00);
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("r3_data", 32'(s_rd_data), 32'(8'h11 * (i + 1)));
            chk("r3_count", 32'(s_count), 32'(2 - i));
        end
        rd_en = 1'b0;
        chk("r3_empty", 32'(s_empty), 32'd1);
        chk("r3_fwft_zero", 32'(f_rd_data), 32'h00);

        // Read while empty: sticky underflow, data holds, clr_err clears.
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("udf_set", 32'(s_udf), 32'd1);
        chk("udf_hold", 32'(s_rd_data), 32'h33);
        chk("udf_count", 32'(s_count), 32'd0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("udf_clr", 32'(s_udf), 32'd0);

        // Fill with wr_en held 18 cycles: full at 16, overflow after.
        wr_en = 1'b1;
        for (int i = 0; i < 18; i++) begin
            wr_data = 8'(8'h40 + i);
            tick();
            if (i == 10) chk("fill_afull_11", 32'(s_afull), 32'd0);
            if (i == 11) chk("fill_afull_12", 32'(s_afull), 32'd1);
            if (i == 15) begin
                chk("fill_full", 32'(s_full), 32'd1);
                chk("fill_count", 32'(s_count), 32'd16);
                chk("fill_ovf0", 32'(s_ovf), 32'd0);
            end
        end
        wr_en = 1'b0;
        chk("ovf_set", 32'(s_ovf), 32'd1);
        chk("ovf_count", 32'(s_count), 32'd16);
        chk("ovf_head", 32'(f_rd_data), 32'h40);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ovf_clr", 32'(s_ovf), 32'd0);

        // Drain: dropped writes must not appear; aempty rises at count 2.
        rd_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("drain_data", 32'(s_rd_data), 32'(8'h40 + k - 1));
            if (k == 13) chk("drain_aempty_3", 32'(s_aempty), 32'd0);
            if (k == 14) chk("drain_aempty_2", 32'(s_aempty), 32'd1);
        end
        rd_en = 1'b0;
        chk("drain_empty", 32'(s_empty), 32'd1);
        chk("drain_count", 32'(s_count), 32'd0);

        // Threshold change at count 11 takes effect on the next edge.
        wr_en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            wr_data = 8'(8'h60 + i);
            tick();
        end
        wr_en = 1'b0;
        chk("th_count", 32'(s_count), 32'd11);
        chk("th_afull0", 32'(s_afull), 32'd0);
        afull_th = 5'd10;
        tick();
        chk("th_afull1", 32'(s_afull), 32'd1);
        afull_th = 5'd12;
        tick();
        chk("th_afull_back", 32'(s_afull), 32'd0);
        rd_en = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        rd_en = 1'b0;
        chk("sim_count0", 32'(s_count), 32'd5);
        chk("sim_data0", 32'(s_rd_data), 32'h65);

        // Simultaneous read/write for 40 cycles at count 5; pointers wrap.
        q = {8'h66, 8'h67, 8'h68, 8'h69, 8'h6A};
        exp_d = 8'h00;
        wr_en = 1'b1;
        rd_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr_data = 8'(8'h80 + i);
            exp_d = q.pop_front();
            q.push_back(wr_data);
            tick();
            chk("sim_data", 32'(s_rd_data), 32'(exp_d));
            chk("sim_count", 32'(s_count), 32'd5);
            chk("sim_head", 32'(f_rd_data), 32'(q[0]));
        end
        last_d = exp_d;
        wr_en = 1'b0;
        rd_en = 1'b0;

        // Fill to full, provoke overflow, then flush with a concurrent write.
        wr_en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            wr_data = 8'(8'hC0 + i);
            tick();
        end
        chk("fl_full", 32'(s_full), 32'd1);
        chk("fl_count16", 32'(s_count), 32'd16);
        tick();
        chk("fl_ovf", 32'(s_ovf), 32'd1);
        flush = 1'b1;
        wr_data = 8'hEE;
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        chk("fl_count", 32'(s_count), 32'd0);
        chk("fl_empty", 32'(s_empty), 32'd1);
        chk("fl_full0", 32'(s_full), 32'd0);
        chk("fl_ovf0", 32'(s_ovf), 32'd0);
        chk("fl_afull", 32'(s_afull), 32'd0);
        chk("fl_aempty", 32'(s_aempty), 32'd1);
        chk("fl_rd_hold", 32'(s_rd_data), 32'(last_d));
        tick();
        chk("fl_discard", 32'(s_empty), 32'd1);

        // FWFT: word written at edge N is visible at N+1 without rd_en.
        wr_en = 1'b1;
        wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        chk("fwft_empty0", 32'(f_empty), 32'd0);
        chk("fwft_data", 32'(f_rd_data), 32'hA5);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("fwft_pop_empty", 32'(f_empty), 32'd1);
        chk("std_after_flush", 32'(s_rd_data), 32'hA5);

        // Asynchronous reset in the middle of a write burst.
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 8'(8'h30 + i);
            tick();
        end
        chk("burst_count", 32'(s_count), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 32'(s_count), 32'd0);
        chk("arst_empty", 32'(s_empty), 32'd1);
        chk("arst_full", 32'(s_full), 32'd0);
        chk("arst_aempty", 32'(s_aempty), 32'd1);
        chk("arst_afull", 32'(s_afull), 32'd0);
        chk("arst_rd_std", 32'(s_rd_data), 32'd0);
        chk("arst_rd_fwft", 32'(f_rd_data), 32'd0);
        wr_en = 1'b0;
        #10 rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
